// File: rtl/cs_pkg.sv
// Shared types and constants for the CS sliding-window block and its output buffer.
package cs_pkg;

  localparam int X_W    = 8;
  localparam int Y_W    = 10;
  localparam int CS_WIN = 9;

  typedef logic [Y_W-1:0] y_t;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } cs_buf_state_t;

endpackage

// File: rtl/cs_y_fifo.sv
// Circular result FIFO with a registered head output (out_data is a flop, not a mem mux).
// Pointers carry one extra MSB so full and empty are distinguishable.
module cs_y_fifo
  import cs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Y_W-1:0]         din,
  output logic [Y_W-1:0]         dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  y_t          dout_q, dout_d;
  y_t          mem_q [DEPTH];
  logic        wr_en, rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = dout_q;

  // A push into a full FIFO only lands when a pop frees the slot on the same edge.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wr_d   = wr_q + {{AW{1'b0}}, wr_en};
    rd_d   = rd_q + {{AW{1'b0}}, rd_en};
    dout_d = dout_q;
    // The new head is the incoming word when it lands exactly at the next read slot.
    if (wr_en && (wr_q == rd_d)) begin
      dout_d = din;
    end else if (rd_en) begin
      dout_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cs_y_buffer.sv
// Output buffer for CS results: drops the WIN-1 warm-up results, queues the rest
// for a valid/ready consumer and counts results lost to back-pressure.
module cs_y_buffer
  import cs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIN   = CS_WIN,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Y_W-1:0]         Y,
  input  logic                   y_stb,
  // Handshake: a word transfers on every rising edge where out_valid and out_ready are both high.
  output logic [Y_W-1:0]         out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   warm,
  output logic                   ovf,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int WC_W = $clog2(WIN);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN - 2);

  cs_buf_state_t   state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic push, pop, drop, full, empty;

  assign push      = y_stb & (state_q == RUN);
  assign pop       = out_valid & out_ready;
  assign drop      = push & full & ~pop;
  assign out_valid = ~empty;
  // warm is the externally visible FSM state.
  assign warm      = (state_q == RUN);
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    case (state_q)
      WARM: begin
        if (y_stb) begin
          if (wcnt_q == WC_LAST) begin
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      RUN: begin
        if (drop) begin
          ovf_d = 1'b1;
          if (drop_q != '1) begin
            drop_d = drop_q + CNT_W'(1);
          end
        end
      end
      default: state_d = WARM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WARM;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  cs_y_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (Y),
    .dout (out_data),
    .full (full),
    .empty(empty),
    .level(level)
  );

endmodule

// File: tb/tb_cs_y_buffer.sv
// Directed bench for cs_y_buffer: warm-up, streaming, overflow, full push+pop,
// pointer wrap and mid-operation reset.
module tb_cs_y_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  Y;
  logic        y_stb;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        warm;
  logic        ovf;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  cs_y_buffer #(.DEPTH(DEPTH), .WIN(9), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Y        (Y),
    .y_stb    (y_stb),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .warm     (warm),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [9:0] v);
    y_stb = 1'b1;
    Y     = v;
    tick();
    y_stb = 1'b0;
    Y     = '0;
  endtask

  task automatic drain_expect(input logic [9:0] v);
    out_ready = 1'b1;
    check_eq("drain_valid", 32'(out_valid), 32'd1);
    check_eq("drain_data", 32'(out_data), 32'(v));
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Y = '0; y_stb = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_warm", 32'(warm), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // warm-up: strobes 1..8 discarded, warm rises on the 8th
    for (int i = 1; i <= 8; i++) begin
      strobe(10'(i));
      check_eq("wu_valid", 32'(out_valid), 32'd0);
      check_eq("wu_warm", 32'(warm), (i == 8) ? 32'd1 : 32'd0);
    end
    strobe(10'h123);
    check_eq("wu_first_valid", 32'(out_valid), 32'd1);
    check_eq("wu_first_data", 32'(out_data), 32'h123);
    check_eq("wu_first_level", 32'(level), 32'd1);
    drain_expect(10'h123);
    check_eq("wu_empty", 32'(out_valid), 32'd0);

    // streaming with out_ready held high
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      y_stb = 1'b1;
      Y = 10'(10'h200 + n);
      tick();
      check_eq("st_valid", 32'(out_valid), 32'd1);
      check_eq("st_data", 32'(out_data), 32'(10'h200 + n));
      check_eq("st_level", 32'(level), 32'd1);
    end
    y_stb = 1'b0;
    tick();
    out_ready = 1'b0;
    check_eq("st_level_end", 32'(level), 32'd0);
    check_eq("st_drop", 32'(drop_cnt), 32'd0);
    check_eq("st_ovf", 32'(ovf), 32'd0);

    // fill past capacity
    for (int i = 0; i < 10; i++) strobe(10'(10'h010 + i));
    check_eq("ov_level", 32'(level), 32'd8);
    check_eq("ov_ovf", 32'(ovf), 32'd1);
    check_eq("ov_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) drain_expect(10'(10'h010 + i));
    check_eq("ov_empty", 32'(out_valid), 32'd0);
    check_eq("ov_level0", 32'(level), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) strobe(10'(10'h020 + i));
    check_eq("fp_level_full", 32'(level), 32'd8);
    out_ready = 1'b1;
    strobe(10'h3FF);
    out_ready = 1'b0;
    check_eq("fp_level", 32'(level), 32'd8);
    check_eq("fp_drop", 32'(drop_cnt), 32'd2);
    for (int i = 1; i < 8; i++) drain_expect(10'(10'h020 + i));
    drain_expect(10'h3FF);
    check_eq("fp_empty", 32'(out_valid), 32'd0);

    // pointer wrap: bursts of 6 pushes then 6 pops, order tracked by the scoreboard
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 6; k++) begin
        exp_q.push_back(10'(10'h080 + r * 6 + k));
        strobe(10'(10'h080 + r * 6 + k));
      end
      check_eq("wr_level", 32'(level), 32'd6);
      for (int k = 0; k < 6; k++) drain_expect(exp_q.pop_front());
    end
    check_eq("wr_empty", 32'(out_valid), 32'd0);
    check_eq("wr_drop", 32'(drop_cnt), 32'd2);

    // reset mid-operation with 5 entries queued and ovf set
    for (int i = 0; i < 5; i++) strobe(10'(10'h040 + i));
    check_eq("mr_level5", 32'(level), 32'd5);
    check_eq("mr_ovf1", 32'(ovf), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mr_valid", 32'(out_valid), 32'd0);
    check_eq("mr_level", 32'(level), 32'd0);
    check_eq("mr_ovf", 32'(ovf), 32'd0);
    check_eq("mr_drop", 32'(drop_cnt), 32'd0);
    check_eq("mr_warm", 32'(warm), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      strobe(10'(10'h300 + i));
      check_eq("mr_wu_valid", 32'(out_valid), 32'd0);
      check_eq("mr_wu_warm", 32'(warm), (i == 8) ? 32'd1 : 32'd0);
    end
    strobe(10'h055);
    check_eq("mr_first_data", 32'(out_data), 32'h055);
    check_eq("mr_first_level", 32'(level), 32'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
